// File: rtl/uart_tx_cfg.sv
// UART transmitter with a write FIFO and per-frame configuration
// (divisor, parity mode, stop bits) captured when each word is popped.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_WID   = 16,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_WID-1:0]   i_div,
  input  logic [1:0]           i_parity,
  input  logic                 i_stop2,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_full,
  output logic [FIFO_AW:0]     o_level,
  output logic                 o_busy,
  output logic                 o_txempty,
  output logic                 o_uart_tx
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]     level_q;
  logic [DIV_WID-1:0]   div_q, div_d;
  logic [DIV_WID-1:0]   cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]     bitc_q, bitc_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_sec_q, stop_sec_d;
  logic                 tx_q, tx_d;

  logic                 full_c, empty_c, push_c, pop_c, start_c, bit_end_c;
  logic [DATA_BITS-1:0] head_c;

  assign full_c    = (level_q == (FIFO_AW+1)'(DEPTH));
  assign empty_c   = (level_q == '0);
  assign push_c    = i_wr & ~full_c & ~i_rst;
  assign head_c    = mem[rd_ptr_q];
  assign bit_end_c = (cnt_q == '0);

  assign o_full    = full_c;
  assign o_level   = level_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_txempty = empty_c & (state_q == S_IDLE);
  assign o_uart_tx = tx_q;

  // Next-state and datapath next values; a frame start pops and latches config
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    bitc_d     = bitc_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_sec_d = stop_sec_q;
    tx_d       = tx_q;
    start_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_c) start_c = 1'b1;
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          bitc_d  = BIT_W'(DATA_BITS - 1);
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_WID'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          cnt_d = div_q;
          if (bitc_q == '0) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              tx_d       = 1'b1;
              stop_sec_d = 1'b0;
            end
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bitc_d  = bitc_q - BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - DIV_WID'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          cnt_d      = div_q;
          stop_sec_d = 1'b0;
        end else begin
          cnt_d = cnt_q - DIV_WID'(1);
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (stop2_q && !stop_sec_q) begin
            stop_sec_d = 1'b1;
            cnt_d      = div_q;
          end else if (!empty_c) begin
            start_c = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DIV_WID'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (start_c) begin
      state_d   = S_START;
      tx_d      = 1'b0;
      cnt_d     = i_div;
      div_d     = i_div;
      shreg_d   = head_c;
      par_en_d  = (i_parity == 2'b01) || (i_parity == 2'b10);
      par_bit_d = (^head_c) ^ (i_parity == 2'b10);
      stop2_d   = i_stop2;
    end
  end

  assign pop_c = start_c;

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge i_clk) begin
    if (push_c) mem[wr_ptr_q] <= i_data;
  end

  // State, FIFO pointers and frame datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      shreg_q    <= '0;
      bitc_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_sec_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      bitc_q     <= bitc_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_sec_q <= stop_sec_d;
      tx_q       <= tx_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + (FIFO_AW+1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame vector table plus FIFO-fill,
// mid-frame divisor change, mid-frame reset and 5-bit data sequences.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div;
  logic [1:0]  parity;
  logic        stop2;
  logic        wr;
  logic [7:0]  data;
  logic        full, busy, txempty, tx;
  logic [4:0]  level;
  logic        wr5;
  logic [4:0]  data5;
  logic        full5, busy5, txempty5, tx5;
  logic [4:0]  level5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(8), .DIV_WID(16), .FIFO_AW(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_div(div), .i_parity(parity), .i_stop2(stop2),
    .i_wr(wr), .i_data(data), .o_full(full), .o_level(level), .o_busy(busy),
    .o_txempty(txempty), .o_uart_tx(tx)
  );

  uart_tx_cfg #(.DATA_BITS(5), .DIV_WID(16), .FIFO_AW(4)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_div(div), .i_parity(parity), .i_stop2(stop2),
    .i_wr(wr5), .i_data(data5), .o_full(full5), .o_level(level5), .o_busy(busy5),
    .o_txempty(txempty5), .o_uart_tx(tx5)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
    logic        stop2;
    logic [11:0] frame;
    int          nb;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [7:0] d);
    wr   = 1'b1;
    data = d;
    step();
    wr   = 1'b0;
  endtask

  // Checks nb bits of f (LSB first), each held d+1 cycles, starting at the next edge
  task automatic run_frame(input logic [11:0] f, input int nb, input int d, input bit sel, input string name);
    for (int k = 0; k < nb; k++) begin
      logic ok;
      ok = 1'b1;
      for (int c = 0; c <= d; c++) begin
        step();
        if ((sel ? tx5 : tx) !== f[k]) ok = 1'b0;
        if (k == 0 && c == 0) check({name, " busy"}, 32'(sel ? busy5 : busy), 32'd1);
      end
      check($sformatf("%s bit%0d", name, k), 32'(ok), 32'd1);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 16'd3, 2'b00, 1'b0, 12'h34A, 10};
    vecs[1] = '{8'h07, 16'd3, 2'b01, 1'b0, 12'h60E, 11};
    vecs[2] = '{8'h07, 16'd3, 2'b10, 1'b0, 12'h40E, 11};
    vecs[3] = '{8'h07, 16'd3, 2'b00, 1'b1, 12'h60E, 11};
    vecs[4] = '{8'h3C, 16'd1, 2'b10, 1'b0, 12'h678, 11};
    vecs[5] = '{8'h00, 16'd2, 2'b01, 1'b1, 12'hC00, 12};

    rst = 1'b1; div = 16'd3; parity = 2'b00; stop2 = 1'b0;
    wr = 1'b0; data = 8'h00; wr5 = 1'b0; data5 = 5'h00;
    repeat (3) step();
    check("rst tx",      32'(tx),      32'd1);
    check("rst level",   32'(level),   32'd0);
    check("rst full",    32'(full),    32'd0);
    check("rst busy",    32'(busy),    32'd0);
    check("rst txempty", 32'(txempty), 32'd1);
    rst = 1'b0;
    step();

    // Single frames across parity/stop/divisor settings
    for (int i = 0; i < 6; i++) begin
      div    = vecs[i].div;
      parity = vecs[i].par;
      stop2  = vecs[i].stop2;
      write_word(vecs[i].data);
      check($sformatf("v%0d level", i), 32'(level), 32'd1);
      check($sformatf("v%0d pre tx", i), 32'(tx), 32'd1);
      run_frame(vecs[i].frame, vecs[i].nb, int'(vecs[i].div), 1'b0, $sformatf("v%0d", i));
      step();
      check($sformatf("v%0d end tx", i),      32'(tx),      32'd1);
      check($sformatf("v%0d end busy", i),    32'(busy),    32'd0);
      check($sformatf("v%0d end txempty", i), 32'(txempty), 32'd1);
    end

    // Fill the FIFO while busy; 17th word dropped, 17 frames back-to-back
    div = 16'd1; parity = 2'b00; stop2 = 1'b0;
    write_word(8'h55);
    fork
      begin
        run_frame(12'h2AA, 10, 1, 1'b0, "prime");
        for (int j = 0; j < 16; j++)
          run_frame(12'({1'b1, 8'(8'h10 + j), 1'b0}), 10, 1, 1'b0, $sformatf("fill%0d", j));
      end
      begin
        step();
        for (int m = 0; m < 17; m++) begin
          wr   = 1'b1;
          data = 8'(8'h10 + m);
          step();
          if (m == 15) begin
            check("fill full16",  32'(full),  32'd1);
            check("fill level16", 32'(level), 32'd16);
          end
        end
        wr = 1'b0;
        check("drop level", 32'(level), 32'd16);
        check("drop full",  32'(full),  32'd1);
      end
    join
    step();
    check("fill txempty", 32'(txempty), 32'd1);
    begin
      logic quiet;
      quiet = 1'b1;
      repeat (20) begin
        step();
        if (tx !== 1'b1) quiet = 1'b0;
      end
      check("fill quiet", 32'(quiet), 32'd1);
    end

    // Divisor change mid-frame affects only the following frame
    div = 16'd3;
    wr = 1'b1; data = 8'hA5;
    step();
    data = 8'h5A;
    fork
      begin
        run_frame(12'h34A, 10, 3, 1'b0, "diva");
        run_frame(12'h2B4, 10, 7, 1'b0, "divb");
      end
      begin
        step();
        wr = 1'b0;
        repeat (12) step();
        div = 16'd7;
      end
    join
    step();
    check("div txempty", 32'(txempty), 32'd1);

    // Reset during the third data bit with two words queued
    div = 16'd3;
    write_word(8'h00);
    write_word(8'h00);
    write_word(8'h00);
    check("rq level", 32'(level), 32'd2);
    repeat (12) step();
    check("rq bit2 low", 32'(tx), 32'd0);
    rst = 1'b1; wr = 1'b1; data = 8'hFF;
    step();
    check("rq tx",      32'(tx),      32'd1);
    check("rq level0",  32'(level),   32'd0);
    check("rq txempty", 32'(txempty), 32'd1);
    check("rq busy",    32'(busy),    32'd0);
    check("rq full",    32'(full),    32'd0);
    rst = 1'b0; wr = 1'b0;
    begin
      logic quiet;
      quiet = 1'b1;
      repeat (60) begin
        step();
        if (tx !== 1'b1 || level !== 5'd0) quiet = 1'b0;
      end
      check("rq quiet", 32'(quiet), 32'd1);
    end

    // Five data bits with even parity
    div = 16'd3; parity = 2'b01; stop2 = 1'b0;
    wr5 = 1'b1; data5 = 5'h1F;
    step();
    wr5 = 1'b0;
    check("db5 level", 32'(level5), 32'd1);
    run_frame(12'h0FE, 8, 3, 1'b1, "db5");
    step();
    check("db5 txempty", 32'(txempty5), 32'd1);
    check("db5 tx",      32'(tx5),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
